// File: rtl/mioc_stim_pkg.sv
// Shared types, gate-function codes and expected-response helper for the MIOC stimulus controller.
package mioc_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } stim_state_e;

    localparam logic [1:0] MIOC_FN_NAND = 2'd0;
    localparam logic [1:0] MIOC_FN_NOR  = 2'd1;
    localparam logic [1:0] MIOC_FN_AND  = 2'd2;
    localparam logic [1:0] MIOC_FN_OR   = 2'd3;

    localparam int unsigned MIOC_NUM_IN  = 2;
    localparam logic [1:0]  MIOC_GATE_FN = MIOC_FN_NAND;

    localparam int unsigned VEC_W = 4;
    localparam int unsigned ERR_W = 5;
    localparam int unsigned CNT_W = 8;

    // Mask of the active input bits; also the last vector of a sweep.
    function automatic logic [VEC_W-1:0] vec_mask(input int unsigned num_in);
        return VEC_W'((5'd1 << num_in) - 5'd1);
    endfunction

    function automatic logic expected_z(input logic [VEC_W-1:0] vec,
                                        input int unsigned      num_in,
                                        input logic [1:0]       gate_fn);
        logic [VEC_W-1:0] mask;
        logic             all_one;
        logic             any_one;
        mask    = vec_mask(num_in);
        all_one = ((vec & mask) == mask);
        any_one = ((vec & mask) != '0);
        case (gate_fn)
            MIOC_FN_NAND: expected_z = ~all_one;
            MIOC_FN_NOR:  expected_z = ~any_one;
            MIOC_FN_AND:  expected_z = all_one;
            default:      expected_z = any_one;
        endcase
    endfunction

endpackage

// File: rtl/mioc_gate_stim_ctrl_if.sv
// Stimulus/response bundle between the stimulus controller and the gate-under-test harness.
interface mioc_gate_stim_ctrl_if;
    import mioc_stim_pkg::*;

    logic             start;
    logic             z;
    logic             in1;
    logic             in2;
    logic             in3;
    logic             in4;
    logic             busy;
    logic             done;
    logic             resp_valid;
    logic [VEC_W-1:0] resp_vec;
    logic             resp_z;
    logic [ERR_W-1:0] err_count;
    logic [VEC_W-1:0] first_fail_vec;
    logic             pass;

    modport master (
        input  start, z,
        output in1, in2, in3, in4, busy, done, resp_valid, resp_vec, resp_z,
               err_count, first_fail_vec, pass
    );

    modport slave (
        output start, z,
        input  in1, in2, in3, in4, busy, done, resp_valid, resp_vec, resp_z,
               err_count, first_fail_vec, pass
    );

endinterface

// File: rtl/mioc_stim_settle_cnt.sv
// Loadable down-counter timing the settle window; term_c flags the final settle cycle.
module mioc_stim_settle_cnt
    import mioc_stim_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             term_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign term_c = (count == CNT_W'(1));

endmodule

// File: rtl/mioc_gate_stim_ctrl.sv
// Sweeps every input vector onto the gate under test, samples z after a settle window and scores it.
// Define MIOC_STIM_CHECK_EN to build the expected-value comparator; otherwise capture-only.
module mioc_gate_stim_ctrl
    import mioc_stim_pkg::*;
#(
    parameter int unsigned NUM_IN        = MIOC_NUM_IN,
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter logic [1:0]  GATE_FN       = MIOC_GATE_FN
) (
    input  logic                  clk,
    input  logic                  rst,
    mioc_gate_stim_ctrl_if.master bus
);

`ifdef MIOC_STIM_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam logic [VEC_W-1:0] LAST_VEC    = vec_mask(NUM_IN);
    localparam int unsigned      STIM_SHIFT  = VEC_W - NUM_IN;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(16);

    stim_state_e      state;
    stim_state_e      next_state;
    logic             settle_term_c;
    logic             mismatch_c;

    logic [VEC_W-1:0] vec_q,        vec_d;
    logic [3:0]       stim_q,       stim_d;
    logic             busy_q,       busy_d;
    logic             done_q,       done_d;
    logic             resp_valid_q, resp_valid_d;
    logic [VEC_W-1:0] resp_vec_q,   resp_vec_d;
    logic             resp_z_q,     resp_z_d;
    logic [ERR_W-1:0] err_q,        err_d;
    logic [VEC_W-1:0] ffv_q,        ffv_d;
    logic             pass_q,       pass_d;

    mioc_stim_settle_cnt u_settle_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state == ST_DRIVE),
        .dec      (state == ST_SETTLE),
        .load_val (SETTLE_LOAD),
        .term_c   (settle_term_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (bus.start) next_state = ST_DRIVE;
            ST_DRIVE:  next_state = ST_SETTLE;
            ST_SETTLE: if (settle_term_c) next_state = ST_SAMPLE;
            ST_SAMPLE: next_state = (vec_q == LAST_VEC) ? ST_DONE : ST_DRIVE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Scored against the response captured on entry to SAMPLE.
    assign mismatch_c = CHECK_EN && (state == ST_SAMPLE) &&
                        (resp_z_q != expected_z(vec_q, NUM_IN, GATE_FN));

    always_comb begin
        vec_d        = vec_q;
        stim_d       = stim_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        resp_valid_d = 1'b0;
        resp_vec_d   = resp_vec_q;
        resp_z_d     = resp_z_q;
        err_d        = err_q;
        ffv_d        = ffv_q;
        pass_d       = pass_q;

        if ((state == ST_IDLE) && bus.start) begin
            vec_d  = '0;
            err_d  = '0;
            ffv_d  = '0;
            pass_d = 1'b0;
        end
        if (state == ST_DRIVE) begin
            stim_d = (vec_q & LAST_VEC) << STIM_SHIFT;
        end
        if ((state == ST_SETTLE) && (next_state == ST_SAMPLE)) begin
            resp_valid_d = 1'b1;
            resp_vec_d   = vec_q;
            resp_z_d     = bus.z;
        end
        if (state == ST_SAMPLE) begin
            if (mismatch_c) begin
                if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
                if (err_q == '0)      ffv_d = vec_q;
            end
            if (vec_q != LAST_VEC) vec_d = vec_q + VEC_W'(1);
        end
        if (next_state == ST_DONE) begin
            stim_d = '0;
            pass_d = (err_d == '0);
        end
        busy_d = (next_state == ST_DRIVE) || (next_state == ST_SETTLE) ||
                 (next_state == ST_SAMPLE);
        done_d = (next_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q        <= '0;
            stim_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_vec_q   <= '0;
            resp_z_q     <= 1'b0;
            err_q        <= '0;
            ffv_q        <= '0;
            pass_q       <= 1'b0;
        end else begin
            vec_q        <= vec_d;
            stim_q       <= stim_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            resp_valid_q <= resp_valid_d;
            resp_vec_q   <= resp_vec_d;
            resp_z_q     <= resp_z_d;
            err_q        <= err_d;
            ffv_q        <= ffv_d;
            pass_q       <= pass_d;
        end
    end

    assign bus.in1            = stim_q[3];
    assign bus.in2            = stim_q[2];
    assign bus.in3            = stim_q[1];
    assign bus.in4            = stim_q[0];
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_vec       = resp_vec_q;
    assign bus.resp_z         = resp_z_q;
    assign bus.err_count      = err_q;
    assign bus.first_fail_vec = ffv_q;
    assign bus.pass           = pass_q;

endmodule

// File: tb/tb_mioc_gate_stim_ctrl.sv
// Directed bench: NAND2/settle 3 and NOR4/settle 1 controllers driven by ideal and stuck gate models.
module tb_mioc_gate_stim_ctrl;
    import mioc_stim_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   mode2  = 0;   // 0 ideal NAND2, 1 z stuck 1, 2 z stuck 0

    always #5 clk = ~clk;

    mioc_gate_stim_ctrl_if bus2 ();
    mioc_gate_stim_ctrl_if bus4 ();

    mioc_gate_stim_ctrl #(.NUM_IN(2), .SETTLE_CYCLES(3), .GATE_FN(MIOC_FN_NAND)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    mioc_gate_stim_ctrl #(.NUM_IN(4), .SETTLE_CYCLES(1), .GATE_FN(MIOC_FN_NOR)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    assign bus2.z = (mode2 == 1) ? 1'b1 : (mode2 == 2) ? 1'b0 : ~(bus2.in1 & bus2.in2);
    assign bus4.z = ~(bus4.in1 | bus4.in2 | bus4.in3 | bus4.in4);

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sweep of the NAND2 unit; start sampled in cycle 0, optional extra start pulse during busy.
    task automatic sweep2(input string name, input int mode, input int pulse_cyc,
                          input logic [4:0] e_err, input logic [3:0] e_ffv, input logic e_pass);
        logic [3:0] nand_tab;
        logic [3:0] vv;
        logic       ez;
        bool_loop: begin end
        nand_tab   = 4'b0111;
        mode2      = mode;
        bus2.start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick();
            bus2.start = (c == pulse_cyc);
            check($sformatf("%s.rv@%0d", name, c), 8'(bus2.resp_valid), 8'((c % 5 == 0) && (c <= 20)));
            check($sformatf("%s.done@%0d", name, c), 8'(bus2.done), 8'(c == 21));
            check($sformatf("%s.busy@%0d", name, c), 8'(bus2.busy), 8'(c <= 20));
            if ((c % 5 == 0) && (c <= 20)) begin
                vv = 4'(c / 5 - 1);
                ez = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : nand_tab[vv[1:0]];
                check($sformatf("%s.vec@%0d", name, c), 8'(bus2.resp_vec), 8'(vv));
                check($sformatf("%s.z@%0d", name, c), 8'(bus2.resp_z), 8'(ez));
                check($sformatf("%s.in@%0d", name, c),
                      8'({bus2.in1, bus2.in2, bus2.in3, bus2.in4}), 8'({vv[1], vv[0], 2'b00}));
            end
            if (c == 21) begin
                check($sformatf("%s.err", name), 8'(bus2.err_count), 8'(e_err));
                check($sformatf("%s.ffv", name), 8'(bus2.first_fail_vec), 8'(e_ffv));
                check($sformatf("%s.pass", name), 8'(bus2.pass), 8'(e_pass));
            end
        end
    endtask

    initial begin
        logic [3:0] vv;
        logic [4:0] e1_err, e0_err;
        logic [3:0] e1_ffv;
        logic       e1_pass, e0_pass;

`ifdef MIOC_STIM_CHECK_EN
        e1_err = 5'd1; e1_ffv = 4'b0011; e1_pass = 1'b0;
        e0_err = 5'd3; e0_pass = 1'b0;
`else
        e1_err = 5'd0; e1_ffv = 4'b0000; e1_pass = 1'b1;
        e0_err = 5'd0; e0_pass = 1'b1;
`endif

        bus2.start = 1'b0;
        bus4.start = 1'b0;
        rst        = 1'b1;
        repeat (3) tick();
        check("rst.busy", 8'(bus2.busy), 8'd0);
        check("rst.done", 8'(bus2.done), 8'd0);
        check("rst.rv", 8'(bus2.resp_valid), 8'd0);
        check("rst.pass", 8'(bus2.pass), 8'd0);
        check("rst.err", 8'(bus2.err_count), 8'd0);
        check("rst.in4", 8'({bus4.in1, bus4.in2, bus4.in3, bus4.in4}), 8'd0);
        rst = 1'b0;
        tick();

        sweep2("ideal", 0, 0, 5'd0, 4'd0, 1'b1);
        sweep2("stuck1", 1, 0, e1_err, e1_ffv, e1_pass);
        sweep2("stuck0", 2, 0, e0_err, 4'd0, e0_pass);
        sweep2("ignstart", 0, 3, 5'd0, 4'd0, 1'b1);

        // NOR4 unit, one settle cycle: a vector every 3 cycles, done at 49.
        bus4.start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            tick();
            bus4.start = 1'b0;
            check($sformatf("nor4.rv@%0d", c), 8'(bus4.resp_valid), 8'((c % 3 == 0) && (c <= 48)));
            check($sformatf("nor4.done@%0d", c), 8'(bus4.done), 8'(c == 49));
            if ((c % 3 == 0) && (c <= 48)) begin
                vv = 4'(c / 3 - 1);
                check($sformatf("nor4.vec@%0d", c), 8'(bus4.resp_vec), 8'(vv));
                check($sformatf("nor4.z@%0d", c), 8'(bus4.resp_z), 8'(vv == 4'd0));
                check($sformatf("nor4.in@%0d", c),
                      8'({bus4.in1, bus4.in2, bus4.in3, bus4.in4}), 8'(vv));
            end
            if (c == 49) begin
                check("nor4.err", 8'(bus4.err_count), 8'd0);
                check("nor4.pass", 8'(bus4.pass), 8'd1);
            end
        end

        // Reset asserted in cycle 8 of a sweep; cycle 9 must show reset values.
        mode2      = 0;
        bus2.start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus2.start = 1'b0;
        end
        check("midrst.pre_busy", 8'(bus2.busy), 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst.busy", 8'(bus2.busy), 8'd0);
        check("midrst.done", 8'(bus2.done), 8'd0);
        check("midrst.rv", 8'(bus2.resp_valid), 8'd0);
        check("midrst.vec", 8'(bus2.resp_vec), 8'd0);
        check("midrst.z", 8'(bus2.resp_z), 8'd0);
        check("midrst.err", 8'(bus2.err_count), 8'd0);
        check("midrst.ffv", 8'(bus2.first_fail_vec), 8'd0);
        check("midrst.pass", 8'(bus2.pass), 8'd0);
        check("midrst.in", 8'({bus2.in1, bus2.in2, bus2.in3, bus2.in4}), 8'd0);
        for (int c = 10; c <= 30; c++) begin
            tick();
            check($sformatf("midrst.idle_done@%0d", c), 8'(bus2.done), 8'd0);
            check($sformatf("midrst.idle_busy@%0d", c), 8'(bus2.busy), 8'd0);
        end

        sweep2("recover", 0, 0, 5'd0, 4'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
